multi_road_intersection: RTL and testbench
==========================================

MULTI_ROAD_INTERSECTION -- requirements
Module: multi_road_intersection

Interface
REQ-001 The block SHALL take parameter NUM_ROADS, default 4: number of roads, range 2..8.
REQ-002 The block SHALL take parameter QUEUE_DEPTH, default 8: plate slots per road queue, power of two.
REQ-003 The block SHALL take parameter PLATE_W, default 5: plate width in bits.
REQ-004 The block SHALL take parameter MAX_CARS, default 30: intersection-wide car limit, at most 31.
REQ-005 The block SHALL take parameter BLIST_DEPTH, default 8: blacklist entries.
REQ-006 The block SHALL take parameter GREEN_INIT, default 40: initial green duration in seconds for every road.
REQ-007 The block SHALL have port clk, input, 1 bit: single clock; one rising edge is one simulated second.
REQ-008 The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-009 The block SHALL have ports op_valid (in, 1), op_code (in, 1; 0=add, 1=remove), op_road (in, clog2(NUM_ROADS)) and plate_in (in, PLATE_W): car operation request.
REQ-010 The block SHALL have ports op_done (out, 1), op_err (out, 1) and removed_plate (out, PLATE_W): operation response.
REQ-011 The block SHALL have ports green (out, NUM_ROADS, one-hot or zero) and remaining_time (out, 7): light state.
REQ-012 The block SHALL have port num_cars (out, NUM_ROADS*5): per-road counts packed, road 0 in the LSBs.
REQ-013 The block SHALL have ports hour (out, 4), minute (out, 6), second (out, 6), am_pm (out, 1; 1=PM) and rush_hour (out, 1): clock state.
REQ-014 The block SHALL have ports bl_rd_en (in, 1), bl_rd_data (out, PLATE_W), bl_count (out, clog2(BLIST_DEPTH)+1) and bl_overflow (out, 1): blacklist access.

Function
REQ-015 A request SHALL be sampled on each clk edge with op_valid=1; op_done SHALL pulse exactly one cycle later, and op_err SHALL be valid with op_done.
REQ-016 An add SHALL be accepted only if the road queue is not full and the total car count is below MAX_CARS; otherwise op_err=1 and no state changes.
REQ-017 A remove SHALL pop the oldest plate of the road (FIFO order) onto removed_plate; a remove from an empty road SHALL set op_err=1 and change nothing.
REQ-018 A successful remove from a road whose green bit was 0 before the edge SHALL append the plate to the blacklist; when the blacklist is full, the plate SHALL be dropped and bl_overflow SHALL be set sticky.
REQ-019 An operation coinciding with a phase change SHALL use the green state from before the edge.
REQ-020 The light FSM SHALL have two states, GREEN and ALL_RED; in GREEN, remaining_time SHALL decrement by 1 per clk.
REQ-021 In GREEN with remaining_time=1, the next cycle SHALL be ALL_RED with green=0 and remaining_time=0.
REQ-022 ALL_RED SHALL last exactly one cycle; it SHALL then advance the active road to (idx+1) mod NUM_ROADS, set its green bit and load its new duration.
REQ-023 The new duration SHALL be the stored road duration +5 if the road has 0..10 cars, unchanged for 11..19 cars and -5 for 20 or more cars.
REQ-024 The new duration SHALL then be clamped to [40,70] when rush_hour=0 or to [30,60] when rush_hour=1, and stored back for that road.
REQ-025 The clock SHALL count 12-hour time: second and minute wrap 59->0; hour goes 12->1 and 11->12; am_pm SHALL toggle on the 11:59:59->12:00:00 transition.
REQ-026 rush_hour SHALL be 1 exactly for 7:00:00-8:59:59 AM and 5:00:00-6:59:59 PM, registered in the same cycle as the time update.
REQ-027 On the transition to 12:00:00 AM, the blacklist SHALL clear (bl_count=0, bl_overflow=0); a same-cycle append SHALL be lost.
REQ-028 bl_rd_en SHALL present blacklist entries round-robin on bl_rd_data one cycle after each pulse, wrapping at bl_count; when bl_count=0, bl_rd_data SHALL be 0.

Reset
REQ-029 rst SHALL force asynchronously: green=1 (road 0), FSM=GREEN, remaining_time=GREEN_INIT, every stored road duration=GREEN_INIT, all queues empty, num_cars=0, time=06:00:00 AM, rush_hour=0, blacklist empty, bl_overflow=0, op_done=0, op_err=0, removed_plate=0, bl_rd_data=0.
REQ-030 A pending request SHALL be discarded when rst asserts mid-operation; no op_done SHALL follow.

Structure
REQ-031 Package intersection_pkg SHALL hold the op_code values, the FSM state enum and the clamp bounds (40/70/30/60) and step (5).
REQ-032 Sub-module road_queue, a circular FIFO (QUEUE_DEPTH x PLATE_W) with count, full and empty outputs, SHALL be instantiated NUM_ROADS times.

Verification
REQ-033 After reset, with no ops, green SHALL equal 0001, 40 cycles later green SHALL be 0000, and the following cycle green SHALL be 0010 with remaining_time=45.
REQ-034 Adding 12 cars to road 2 before its turn SHALL make road 2 receive a duration of 40 (unchanged) when it turns green.
REQ-035 When road 0 is red, a remove of plate 5'h13 from road 0 SHALL give removed_plate=0x13 and bl_count=1; a green-road remove SHALL leave bl_count unchanged.
REQ-036 After 30 accepted adds, the 31st add SHALL return op_err=1 with num_cars unchanged; a remove from an empty road SHALL return op_err=1.
REQ-037 With the time preset to 6:59:59 AM, one clk SHALL set rush_hour=1; at 11:59:59 PM, one clk SHALL give 12:00:00 AM with bl_count=0.
REQ-038 Asserting rst during a remove SHALL give no op_done and leave all queues empty.

Source files
------------

// File: rtl/intersection_pkg.sv
// Shared op codes, light FSM encoding, duration bounds and the per-turn duration update.
package intersection_pkg;
  localparam logic OP_ADD    = 1'b0;
  localparam logic OP_REMOVE = 1'b1;

  typedef enum logic [0:0] {ST_GREEN = 1'b0, ST_ALL_RED = 1'b1} light_state_e;

  localparam logic [6:0] DUR_MIN_NORM = 7'd40;
  localparam logic [6:0] DUR_MAX_NORM = 7'd70;
  localparam logic [6:0] DUR_MIN_RUSH = 7'd30;
  localparam logic [6:0] DUR_MAX_RUSH = 7'd60;
  localparam logic [6:0] DUR_STEP     = 7'd5;
  localparam logic [4:0] FEW_CARS     = 5'd10;
  localparam logic [4:0] MANY_CARS    = 5'd20;

  // Light roads get longer turns, busy roads shorter, then clamp to the current window.
  function automatic logic [6:0] next_duration(input logic [6:0] dur, input logic [4:0] cars,
                                               input logic rush);
    logic [6:0] d, lo, hi;
    if (cars <= FEW_CARS)       d = dur + DUR_STEP;
    else if (cars >= MANY_CARS) d = dur - DUR_STEP;
    else                        d = dur;
    lo = rush ? DUR_MIN_RUSH : DUR_MIN_NORM;
    hi = rush ? DUR_MAX_RUSH : DUR_MAX_NORM;
    if (d < lo)      d = lo;
    else if (d > hi) d = hi;
    return d;
  endfunction
endpackage

// File: rtl/multi_road_intersection_if.sv
// Car operation request/response bundle between a requester and the intersection.
interface multi_road_intersection_if #(
  parameter int NUM_ROADS = 4,
  parameter int PLATE_W   = 5
) ();
  localparam int ROAD_W = (NUM_ROADS > 1) ? $clog2(NUM_ROADS) : 1;

  logic               op_valid;
  logic               op_code;
  logic [ROAD_W-1:0]  op_road;
  logic [PLATE_W-1:0] plate_in;
  logic               op_done;
  logic               op_err;
  logic [PLATE_W-1:0] removed_plate;

  modport master (output op_valid, op_code, op_road, plate_in,
                  input  op_done, op_err, removed_plate);
  modport slave  (input  op_valid, op_code, op_road, plate_in,
                  output op_done, op_err, removed_plate);
endinterface

// File: rtl/road_queue.sv
// Circular plate FIFO for one road; the head entry is visible combinationally for pops.
module road_queue #(
  parameter int DEPTH = 8,
  parameter int W     = 5,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);
  logic [DEPTH-1:0][W-1:0] mem;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= din;

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
endmodule

// File: rtl/multi_road_intersection.sv
// Round-robin traffic light with per-road plate queues, adaptive green time,
// a 12-hour wall clock and a blacklist of plates removed on red.
module multi_road_intersection
  import intersection_pkg::*;
#(
  parameter int NUM_ROADS   = 4,
  parameter int QUEUE_DEPTH = 8,
  parameter int PLATE_W     = 5,
  parameter int MAX_CARS    = 30,
  parameter int BLIST_DEPTH = 8,
  parameter int GREEN_INIT  = 40
) (
  input  logic                            clk,
  input  logic                            rst,
  multi_road_intersection_if.slave        op,
  output logic [NUM_ROADS-1:0]            green,
  output logic [6:0]                      remaining_time,
  output logic [NUM_ROADS*5-1:0]          num_cars,
  output logic [3:0]                      hour,
  output logic [5:0]                      minute,
  output logic [5:0]                      second,
  output logic                            am_pm,
  output logic                            rush_hour,
  input  logic                            bl_rd_en,
  output logic [PLATE_W-1:0]              bl_rd_data,
  output logic [$clog2(BLIST_DEPTH):0]    bl_count,
  output logic                            bl_overflow
);
  localparam int ROAD_W = (NUM_ROADS > 1) ? $clog2(NUM_ROADS) : 1;
  localparam int CW     = $clog2(QUEUE_DEPTH) + 1;
  localparam int BW     = $clog2(BLIST_DEPTH);

  logic [NUM_ROADS-1:0]              q_push, q_pop, q_full, q_empty;
  logic [NUM_ROADS-1:0][PLATE_W-1:0] q_head;
  logic [NUM_ROADS-1:0][CW-1:0]      q_count;
  logic [5:0]         total;
  logic               road_ok, sel_full, sel_empty, sel_green;
  logic [PLATE_W-1:0] sel_head;
  logic               add_ok, rem_ok, bl_append, midnight;

  light_state_e                  state;
  logic [ROAD_W-1:0]             idx, nxt_idx;
  logic [NUM_ROADS-1:0][6:0]     dur;
  logic [6:0]                    nxt_dur, new_dur;
  logic [4:0]                    nxt_cars;

  genvar r;
  for (r = 0; r < NUM_ROADS; r++) begin : g_road
    assign q_push[r] = add_ok && (op.op_road == ROAD_W'(r));
    assign q_pop[r]  = rem_ok && (op.op_road == ROAD_W'(r));
    road_queue #(.DEPTH(QUEUE_DEPTH), .W(PLATE_W)) u_q (
      .clk(clk), .rst(rst), .push(q_push[r]), .pop(q_pop[r]), .din(op.plate_in),
      .dout(q_head[r]), .count(q_count[r]), .full(q_full[r]), .empty(q_empty[r]));
    assign num_cars[r*5 +: 5] = 5'(q_count[r]);
  end

  // Road selects are done by match loops so an unused op_road code simply finds no road.
  always_comb begin
    total = '0; road_ok = 1'b0; sel_full = 1'b0; sel_empty = 1'b1; sel_head = '0;
    nxt_idx  = (idx == ROAD_W'(NUM_ROADS - 1)) ? '0 : idx + 1'b1;
    nxt_cars = '0; nxt_dur = '0;
    for (int i = 0; i < NUM_ROADS; i++) begin
      total = total + 6'(q_count[i]);
      if (op.op_road == ROAD_W'(i)) begin
        road_ok = 1'b1; sel_full = q_full[i]; sel_empty = q_empty[i]; sel_head = q_head[i];
      end
      if (nxt_idx == ROAD_W'(i)) begin
        nxt_cars = 5'(q_count[i]); nxt_dur = dur[i];
      end
    end
  end

  assign green     = (state == ST_GREEN) ? (NUM_ROADS'(1) << idx) : '0;
  assign sel_green = (state == ST_GREEN) && (idx == op.op_road);
  assign add_ok    = op.op_valid && (op.op_code == OP_ADD) && road_ok && !sel_full
                     && (total < 6'(MAX_CARS));
  assign rem_ok    = op.op_valid && (op.op_code == OP_REMOVE) && road_ok && !sel_empty;
  assign bl_append = rem_ok && !sel_green;
  assign new_dur   = next_duration(nxt_dur, nxt_cars, rush_hour);

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      op.op_done <= 1'b0; op.op_err <= 1'b0; op.removed_plate <= '0;
    end else begin
      op.op_done <= op.op_valid;
      op.op_err  <= op.op_valid && !(add_ok || rem_ok);
      if (rem_ok) op.removed_plate <= sel_head;
    end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= ST_GREEN; idx <= '0;
      remaining_time <= 7'(GREEN_INIT);
      dur <= {NUM_ROADS{7'(GREEN_INIT)}};
    end else if (state == ST_GREEN) begin
      if (remaining_time == 7'd1) begin
        state <= ST_ALL_RED; remaining_time <= '0;
      end else remaining_time <= remaining_time - 1'b1;
    end else begin
      state <= ST_GREEN; idx <= nxt_idx;
      remaining_time <= new_dur; dur[nxt_idx] <= new_dur;
    end

  logic sec_wrap, min_wrap, pm_n;
  logic [3:0] hour_n;
  assign sec_wrap = (second == 6'd59);
  assign min_wrap = sec_wrap && (minute == 6'd59);
  assign midnight = min_wrap && (hour == 4'd11) && am_pm;

  always_comb begin
    hour_n = hour; pm_n = am_pm;
    if (min_wrap) begin
      hour_n = (hour == 4'd12) ? 4'd1 : hour + 1'b1;
      if (hour == 4'd11) pm_n = ~am_pm;
    end
  end

  // rush_hour follows the new time so both change on the same edge.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      hour <= 4'd6; minute <= '0; second <= '0; am_pm <= 1'b0; rush_hour <= 1'b0;
    end else begin
      second <= sec_wrap ? '0 : second + 1'b1;
      if (sec_wrap) minute <= min_wrap ? '0 : minute + 1'b1;
      hour  <= hour_n;
      am_pm <= pm_n;
      rush_hour <= pm_n ? (hour_n == 4'd5 || hour_n == 4'd6)
                        : (hour_n == 4'd7 || hour_n == 4'd8);
    end

  logic [BLIST_DEPTH-1:0][PLATE_W-1:0] bl_mem;
  logic [BW-1:0] bl_rd_ptr;
  logic [BW:0]   rd_ptr_inc;
  logic          bl_full;
  assign bl_full    = (bl_count == (BW+1)'(BLIST_DEPTH));
  assign rd_ptr_inc = {1'b0, bl_rd_ptr} + 1'b1;

  always_ff @(posedge clk)
    if (bl_append && !bl_full) bl_mem[BW'(bl_count)] <= sel_head;

  // The midnight clear wins over any same-cycle append or read.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      bl_count <= '0; bl_overflow <= 1'b0; bl_rd_ptr <= '0; bl_rd_data <= '0;
    end else if (midnight) begin
      bl_count <= '0; bl_overflow <= 1'b0; bl_rd_ptr <= '0; bl_rd_data <= '0;
    end else begin
      if (bl_append) begin
        if (bl_full) bl_overflow <= 1'b1;
        else         bl_count <= bl_count + 1'b1;
      end
      if (bl_rd_en) begin
        if (bl_count == '0) bl_rd_data <= '0;
        else begin
          bl_rd_data <= bl_mem[bl_rd_ptr];
          bl_rd_ptr  <= (rd_ptr_inc >= bl_count) ? '0 : bl_rd_ptr + 1'b1;
        end
      end
    end
endmodule

// File: tb/tb_multi_road_intersection.sv
// Randomized scoreboard bench: a time-of-day/queue model predicts every cycle's outputs.
module tb_multi_road_intersection;
  localparam int NR = 4, QD = 16, PW = 5, MC = 30, BD = 8, GI = 40;

  logic clk = 1'b0, rst = 1'b1, bl_rd_en = 1'b0;
  logic [NR-1:0] green;
  logic [6:0] remaining_time;
  logic [NR*5-1:0] num_cars;
  logic [3:0] hour;
  logic [5:0] minute, second;
  logic am_pm, rush_hour, bl_overflow;
  logic [PW-1:0] bl_rd_data;
  logic [3:0] bl_count;

  multi_road_intersection_if #(.NUM_ROADS(NR), .PLATE_W(PW)) op ();

  multi_road_intersection #(.NUM_ROADS(NR), .QUEUE_DEPTH(QD), .PLATE_W(PW), .MAX_CARS(MC),
                            .BLIST_DEPTH(BD), .GREEN_INIT(GI)) dut (
    .clk(clk), .rst(rst), .op(op), .green(green), .remaining_time(remaining_time),
    .num_cars(num_cars), .hour(hour), .minute(minute), .second(second), .am_pm(am_pm),
    .rush_hour(rush_hour), .bl_rd_en(bl_rd_en), .bl_rd_data(bl_rd_data),
    .bl_count(bl_count), .bl_overflow(bl_overflow));

  always #5 clk = ~clk;

  typedef struct {
    bit has_op; bit err; bit chk; logic [4:0] plate; logic [63:0] st;
  } exp_t;
  exp_t st_q[$];

  int tests = 0, fails = 0;

  // Reference model: queues per road, time as seconds since midnight.
  logic [4:0] mq[NR][$];
  logic [4:0] bl[$];
  int tod, active, rem, rd_i;
  int dur[NR];
  bit in_red, ovf;
  logic [4:0] rd_data;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] want);
    tests++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, want, $time);
    end
  endtask

  function automatic logic [63:0] pk(logic [3:0] g, logic [6:0] rt, logic [19:0] cars,
      logic [3:0] hr, logic [5:0] mn, logic [5:0] sc, logic pm, logic rush,
      logic [3:0] blc, logic ov, logic [4:0] rd);
    return {5'd0, g, rt, cars, hr, mn, sc, pm, rush, blc, ov, rd};
  endfunction

  function automatic logic [63:0] dut_st();
    return pk(green, remaining_time, num_cars, hour, minute, second, am_pm, rush_hour,
              bl_count, bl_overflow, bl_rd_data);
  endfunction

  function automatic bit rush_of(int t);
    int h = t / 3600;
    return h == 7 || h == 8 || h == 17 || h == 18;
  endfunction

  function automatic int model_total();
    int s = 0;
    for (int i = 0; i < NR; i++) s += mq[i].size();
    return s;
  endfunction

  function automatic logic [19:0] model_cars();
    logic [19:0] c = '0;
    for (int i = 0; i < NR; i++) c[i*5 +: 5] = 5'(mq[i].size());
    return c;
  endfunction

  function automatic logic [63:0] model_st();
    int h24 = tod / 3600;
    int h12 = (h24 % 12 == 0) ? 12 : h24 % 12;
    logic [3:0] g = in_red ? 4'b0 : 4'(1 << active);
    return pk(g, 7'(rem), model_cars(), 4'(h12), 6'((tod / 60) % 60), 6'(tod % 60),
              h24 >= 12, rush_of(tod), 4'(bl.size()), ovf, rd_data);
  endfunction

  task automatic model_init();
    for (int i = 0; i < NR; i++) begin mq[i].delete(); dur[i] = GI; end
    bl.delete();
    tod = 6 * 3600; active = 0; rem = GI; in_red = 0; ovf = 0; rd_i = 0; rd_data = '0;
  endtask

  // Advance the model by one second given the inputs sampled at that edge.
  task automatic model_step(bit v, bit code, int road, logic [4:0] plate, bit rd);
    exp_t e;
    int gr, n, d, lo, hi;
    bit pre_rush;
    pre_rush = rush_of(tod);
    gr = in_red ? -1 : active;
    e.has_op = v; e.err = 0; e.chk = 0; e.plate = '0;
    if (rd) begin
      if (bl.size() == 0) rd_data = '0;
      else begin rd_data = bl[rd_i]; rd_i = (rd_i + 1) % bl.size(); end
    end
    if (!in_red) begin
      if (rem == 1) begin in_red = 1; rem = 0; end
      else rem--;
    end else begin
      active = (active + 1) % NR;
      n = mq[active].size();
      d = dur[active] + ((n <= 10) ? 5 : (n >= 20) ? -5 : 0);
      lo = pre_rush ? 30 : 40; hi = pre_rush ? 60 : 70;
      if (d < lo) d = lo;
      if (d > hi) d = hi;
      dur[active] = d; rem = d; in_red = 0;
    end
    if (v) begin
      if (code == 1'b0) begin
        if (mq[road].size() < QD && model_total() < MC) mq[road].push_back(plate);
        else e.err = 1;
      end else if (mq[road].size() == 0) e.err = 1;
      else begin
        e.plate = mq[road].pop_front(); e.chk = 1;
        if (road != gr) begin
          if (bl.size() < BD) bl.push_back(e.plate);
          else ovf = 1;
        end
      end
    end
    tod = (tod + 1) % 86400;
    if (tod == 0) begin bl.delete(); ovf = 0; rd_i = 0; rd_data = '0; end
    e.st = model_st();
    st_q.push_back(e);
  endtask

  task automatic step(bit v, bit code, int road, logic [4:0] plate, bit rd);
    @(negedge clk);
    op.op_valid = v; op.op_code = code; op.op_road = 2'(road); op.plate_in = plate;
    bl_rd_en = rd;
    model_step(v, code, road, plate, rd);
  endtask

  task automatic settle();
    @(posedge clk); #2;
  endtask

  task automatic release_rst();
    @(negedge clk);
    rst = 1'b0;
    model_step(0, 0, 0, '0, 0);
  endtask

  exp_t me;
  always @(posedge clk) begin
    #1;
    if (!rst) begin
      if (st_q.size() > 0) begin
        me = st_q.pop_front();
        check("op_done", 64'(op.op_done), 64'(me.has_op));
        if (me.has_op) check("op_err", 64'(op.op_err), 64'(me.err));
        if (me.chk) check("removed_plate", 64'(op.removed_plate), 64'(me.plate));
        check("status", dut_st(), me.st);
      end else check("spurious_done", 64'(op.op_done), 64'd0);
    end
  end

  initial begin
    bit found;
    op.op_valid = 0; op.op_code = 0; op.op_road = '0; op.plate_in = '0;
    model_init();
    #12;
    check("rst_green", 64'(green), 64'h1);
    check("rst_time", {hour, minute, second, am_pm, rush_hour}, {4'd6, 6'd0, 6'd0, 1'b0, 1'b0});
    check("rst_misc", {remaining_time, num_cars, bl_count, bl_overflow, bl_rd_data},
          {7'd40, 20'd0, 4'd0, 1'b0, 5'd0});
    check("rst_op", {op.op_done, op.op_err, op.removed_plate}, 64'd0);
    release_rst();

    // Idle to the first phase change.
    for (int i = 0; i < 39; i++) step(0, 0, 0, '0, 0);
    settle(); check("all_red", 64'(green), 64'h0);
    step(0, 0, 0, '0, 0);
    settle(); check("road1_green", {green, remaining_time}, {4'b0010, 7'd45});

    // 12 cars wait on road 2; its turn keeps the stored 40.
    for (int i = 0; i < 12; i++) step(1, 0, 2, 5'(i + 1), 0);
    found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      step(0, 0, 0, '0, 0);
      settle();
      if (green == 4'b0100) found = 1;
    end
    check("road2_turn_seen", 64'(found), 64'd1);
    check("road2_duration", 64'(remaining_time), 64'd40);

    // Red-road remove blacklists, empty remove errors, green-road remove does not list.
    step(1, 0, 0, 5'h13, 0);
    step(1, 1, 0, '0, 0);
    settle(); check("red_remove", {op.removed_plate, bl_count}, {5'h13, 4'd1});
    step(1, 1, 1, '0, 0);
    settle(); check("empty_remove_err", 64'(op.op_err), 64'd1);
    step(1, 1, 2, '0, 0);
    settle(); check("green_remove_bl", 64'(bl_count), 64'd1);

    // Fill to the car limit, then one more add must be refused.
    for (int i = 0; i < 40 && model_total() < MC; i++) step(1, 0, (i % 3 == 2) ? 3 : i % 3, 5'(i), 0);
    step(1, 0, 0, 5'h1f, 0);
    settle(); check("limit_err", {op.op_err, num_cars}, {1'b1, model_cars()});

    // Reset while a remove is in flight.
    step(1, 1, 0, '0, 0);
    #2; rst = 1'b1; st_q.delete();
    op.op_valid = 0;
    settle(); check("rst_no_done", 64'(op.op_done), 64'd0);
    settle(); check("rst_queues", {num_cars, green}, {20'd0, 4'b0001});
    model_init();
    release_rst();

    // Long randomized run through rush hour and midnight.
    for (int i = 0; i < 64850; i++) begin
      bit v, c, rd;
      v = $urandom_range(0, 99) < 60;
      c = $urandom_range(0, 99) >= 55;
      rd = $urandom_range(0, 9) == 0;
      step(v, c, $urandom_range(0, NR - 1), 5'($urandom), rd);
      if (tod == 7 * 3600) begin
        settle(); check("rush_start", {hour, rush_hour}, {4'd7, 1'b1});
      end
      if (tod == 0) begin
        settle();
        check("midnight", {hour, minute, second, am_pm, bl_count, bl_overflow},
              {4'd12, 6'd0, 6'd0, 1'b0, 4'd0, 1'b0});
      end
    end
    step(0, 0, 0, '0, 0);
    settle(); settle();
    check("scoreboard_drained", 64'(st_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
